// File: rtl/axi_ar_arbiter_if.sv
// AR-channel bundle for the two-master read-address arbiter: both master AR ports,
// the shared slave-side AR bus, the observed slave R handshake and the DECERR responder.
interface axi_ar_arbiter_if #(
  parameter int ID_W   = 4,
  parameter int IDS_W  = 8,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4,
  parameter int SIZE_W = 3,
  parameter int DATA_W = 32
);
  logic [ID_W-1:0]   ARID_M0, ARID_M1;
  logic [ADDR_W-1:0] ARADDR_M0, ARADDR_M1;
  logic [LEN_W-1:0]  ARLEN_M0, ARLEN_M1;
  logic [SIZE_W-1:0] ARSIZE_M0, ARSIZE_M1;
  logic [1:0]        ARBURST_M0, ARBURST_M1;
  logic              ARVALID_M0, ARVALID_M1;
  logic              ARREADY_M0, ARREADY_M1;

  logic [IDS_W-1:0]  ARID_S;
  logic [ADDR_W-1:0] ARADDR_S;
  logic [LEN_W-1:0]  ARLEN_S;
  logic [SIZE_W-1:0] ARSIZE_S;
  logic [1:0]        ARBURST_S;
  logic              ARVALID_S, ARREADY_S;
  logic              RVALID_S, RREADY_S, RLAST_S;

  logic [1:0]        GRANT;
  logic [IDS_W-1:0]  RID_D;
  logic [DATA_W-1:0] RDATA_D;
  logic [1:0]        RRESP_D;
  logic              RLAST_D, RVALID_D, RREADY_D;

  // Arbiter side: accepts master requests, drives the decoder and the DECERR beats.
  modport slave (
    input  ARID_M0, ARADDR_M0, ARLEN_M0, ARSIZE_M0, ARBURST_M0, ARVALID_M0,
    input  ARID_M1, ARADDR_M1, ARLEN_M1, ARSIZE_M1, ARBURST_M1, ARVALID_M1,
    output ARREADY_M0, ARREADY_M1,
    output ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    input  ARREADY_S, RVALID_S, RREADY_S, RLAST_S,
    output GRANT, RID_D, RDATA_D, RRESP_D, RLAST_D, RVALID_D,
    input  RREADY_D
  );

  // Environment side: masters, decoder/slave and the R-path consumer.
  modport master (
    output ARID_M0, ARADDR_M0, ARLEN_M0, ARSIZE_M0, ARBURST_M0, ARVALID_M0,
    output ARID_M1, ARADDR_M1, ARLEN_M1, ARSIZE_M1, ARBURST_M1, ARVALID_M1,
    input  ARREADY_M0, ARREADY_M1,
    input  ARID_S, ARADDR_S, ARLEN_S, ARSIZE_S, ARBURST_S, ARVALID_S,
    output ARREADY_S, RVALID_S, RREADY_S, RLAST_S,
    input  GRANT, RID_D, RDATA_D, RRESP_D, RLAST_D, RVALID_D,
    output RREADY_D
  );
endinterface

// File: rtl/axi_ar_arbiter.sv
// Round-robin AR arbiter for two masters; holds the grant until the burst's last R beat
// and answers unmapped addresses itself with DECERR beats.
module axi_ar_arbiter #(
  parameter int ID_W   = 4,
  parameter int IDS_W  = 8,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 4,
  parameter int SIZE_W = 3,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] MAP_TOP = 'h1_FFFF
) (
  input logic             ACLK,
  input logic             ARESETn,
  axi_ar_arbiter_if.slave bus
);
  // state | meaning
  // IDLE  | no owner, arbitrating master requests
  // ADDR  | presenting latched request to the decoder
  // DATA  | waiting for the slave's last R beat
  // DERR  | unmapped address, returning DECERR beats locally
  typedef enum logic [1:0] {IDLE, ADDR, DATA, DERR} state_t;

  localparam int TAG_W = IDS_W - ID_W;

  state_t            r_state, w_next;
  logic              r_last_m1;
  logic [1:0]        r_grant;
  logic [IDS_W-1:0]  r_id;
  logic [ADDR_W-1:0] r_addr;
  logic [LEN_W-1:0]  r_len;
  logic [SIZE_W-1:0] r_size;
  logic [1:0]        r_burst;
  logic [LEN_W-1:0]  r_cnt;
  logic              w_rdy0, w_rdy1, w_derr_last;

  assign w_derr_last = (r_cnt == r_len);

  always_ff @(posedge ACLK) begin
    if (!ARESETn) r_state <= IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    w_rdy0 = 1'b0;
    w_rdy1 = 1'b0;
    case (r_state)
      IDLE: begin
        // last owner yields on a tie
        w_rdy0 = bus.ARVALID_M0 & (~bus.ARVALID_M1 | r_last_m1);
        w_rdy1 = bus.ARVALID_M1 & (~bus.ARVALID_M0 | ~r_last_m1);
        if (w_rdy0)      w_next = (bus.ARADDR_M0 <= MAP_TOP) ? ADDR : DERR;
        else if (w_rdy1) w_next = (bus.ARADDR_M1 <= MAP_TOP) ? ADDR : DERR;
      end
      ADDR: if (bus.ARREADY_S) w_next = DATA;
      DATA: if (bus.RVALID_S & bus.RREADY_S & bus.RLAST_S) w_next = IDLE;
      DERR: if (bus.RREADY_D & w_derr_last) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      r_last_m1 <= 1'b1;
      r_grant   <= 2'b00;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_size    <= '0;
      r_burst   <= '0;
      r_cnt     <= '0;
    end else begin
      if (w_rdy0) begin
        r_id      <= {TAG_W'(0), bus.ARID_M0};
        r_addr    <= bus.ARADDR_M0;
        r_len     <= bus.ARLEN_M0;
        r_size    <= bus.ARSIZE_M0;
        r_burst   <= bus.ARBURST_M0;
        r_grant   <= 2'b01;
        r_last_m1 <= 1'b0;
      end else if (w_rdy1) begin
        r_id      <= {TAG_W'(1), bus.ARID_M1};
        r_addr    <= bus.ARADDR_M1;
        r_len     <= bus.ARLEN_M1;
        r_size    <= bus.ARSIZE_M1;
        r_burst   <= bus.ARBURST_M1;
        r_grant   <= 2'b10;
        r_last_m1 <= 1'b1;
      end
      if (r_state != IDLE && w_next == IDLE) r_grant <= 2'b00;
      if (r_state == DERR && bus.RREADY_D)
        r_cnt <= w_derr_last ? '0 : r_cnt + 1'b1;
    end
  end

  assign bus.ARREADY_M0 = w_rdy0;
  assign bus.ARREADY_M1 = w_rdy1;
  assign bus.ARID_S     = r_id;
  assign bus.ARADDR_S   = r_addr;
  assign bus.ARLEN_S    = r_len;
  assign bus.ARSIZE_S   = r_size;
  assign bus.ARBURST_S  = r_burst;
  assign bus.ARVALID_S  = (r_state == ADDR);
  assign bus.GRANT      = r_grant;
  assign bus.RID_D      = r_id;
  assign bus.RDATA_D    = '0;
  assign bus.RVALID_D   = (r_state == DERR);
  assign bus.RRESP_D    = {2{bus.RVALID_D}};
  assign bus.RLAST_D    = bus.RVALID_D & w_derr_last;
endmodule

// File: tb/tb_axi_ar_arbiter.sv
// Directed bench for axi_ar_arbiter: arbitration, address stall, DECERR, alternation, reset.
module tb_axi_ar_arbiter;
  logic ACLK = 1'b0;
  logic ARESETn;
  int   n_vec = 0;
  int   n_err = 0;

  axi_ar_arbiter_if bus ();
  axi_ar_arbiter dut (.ACLK(ACLK), .ARESETn(ARESETn), .bus(bus));

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    @(negedge ACLK);
  endtask

  task automatic idle_inputs();
    bus.ARVALID_M0 = 0; bus.ARVALID_M1 = 0; bus.ARREADY_S = 0;
    bus.RVALID_S = 0; bus.RREADY_S = 0; bus.RLAST_S = 0; bus.RREADY_D = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    bus.ARID_M0 = 0; bus.ARADDR_M0 = 0; bus.ARLEN_M0 = 0; bus.ARSIZE_M0 = 3'd2; bus.ARBURST_M0 = 2'b01;
    bus.ARID_M1 = 0; bus.ARADDR_M1 = 0; bus.ARLEN_M1 = 0; bus.ARSIZE_M1 = 3'd2; bus.ARBURST_M1 = 2'b01;
    ARESETn = 0;
    tick(); tick();
    n_vec++; if (bus.GRANT !== 2'b00) begin n_err++; $display("FAIL rst_grant: got %b want 00", bus.GRANT); end
    n_vec++; if (bus.ARVALID_S !== 1'b0) begin n_err++; $display("FAIL rst_arvalid_s: got %b want 0", bus.ARVALID_S); end
    n_vec++; if (bus.RVALID_D !== 1'b0) begin n_err++; $display("FAIL rst_rvalid_d: got %b want 0", bus.RVALID_D); end
    n_vec++; if (bus.ARADDR_S !== 32'h0) begin n_err++; $display("FAIL rst_araddr_s: got %h want 0", bus.ARADDR_S); end
    n_vec++; if (bus.ARID_S !== 8'h00) begin n_err++; $display("FAIL rst_arid_s: got %h want 00", bus.ARID_S); end
    ARESETn = 1;
    tick();
  endtask

  task automatic test_tie();
    bus.ARID_M0 = 4'h3; bus.ARADDR_M0 = 32'h100;   bus.ARLEN_M0 = 0;
    bus.ARID_M1 = 4'h7; bus.ARADDR_M1 = 32'h10004; bus.ARLEN_M1 = 0;
    bus.ARVALID_M0 = 1; bus.ARVALID_M1 = 1;
    #1;
    n_vec++; if (bus.ARREADY_M0 !== 1'b1) begin n_err++; $display("FAIL tie_rdy0: got %b want 1", bus.ARREADY_M0); end
    n_vec++; if (bus.ARREADY_M1 !== 1'b0) begin n_err++; $display("FAIL tie_rdy1: got %b want 0", bus.ARREADY_M1); end
    tick();
    bus.ARVALID_M0 = 0;
    #1;
    n_vec++; if (bus.GRANT !== 2'b01) begin n_err++; $display("FAIL tie_grant0: got %b want 01", bus.GRANT); end
    n_vec++; if (bus.ARVALID_S !== 1'b1) begin n_err++; $display("FAIL tie_arvalid: got %b want 1", bus.ARVALID_S); end
    n_vec++; if (bus.ARID_S !== 8'h03) begin n_err++; $display("FAIL tie_arid0: got %h want 03", bus.ARID_S); end
    n_vec++; if (bus.ARADDR_S !== 32'h100) begin n_err++; $display("FAIL tie_addr0: got %h want 100", bus.ARADDR_S); end
    n_vec++; if (bus.ARREADY_M1 !== 1'b0) begin n_err++; $display("FAIL tie_busy_rdy1: got %b want 0", bus.ARREADY_M1); end
    bus.ARREADY_S = 1;
    tick();
    bus.ARREADY_S = 0;
    n_vec++; if (bus.ARVALID_S !== 1'b0) begin n_err++; $display("FAIL tie_data_arvalid: got %b want 0", bus.ARVALID_S); end
    bus.RVALID_S = 1; bus.RREADY_S = 1; bus.RLAST_S = 1;
    tick();
    bus.RVALID_S = 0; bus.RREADY_S = 0; bus.RLAST_S = 0;
    #1;
    n_vec++; if (bus.GRANT !== 2'b00) begin n_err++; $display("FAIL tie_grant_clr: got %b want 00", bus.GRANT); end
    n_vec++; if (bus.ARREADY_M1 !== 1'b1) begin n_err++; $display("FAIL tie_rdy1_next: got %b want 1", bus.ARREADY_M1); end
    tick();
    bus.ARVALID_M1 = 0;
    n_vec++; if (bus.GRANT !== 2'b10) begin n_err++; $display("FAIL tie_grant1: got %b want 10", bus.GRANT); end
    n_vec++; if (bus.ARID_S !== 8'h17) begin n_err++; $display("FAIL tie_arid1: got %h want 17", bus.ARID_S); end
    n_vec++; if (bus.ARADDR_S !== 32'h10004) begin n_err++; $display("FAIL tie_addr1: got %h want 10004", bus.ARADDR_S); end
    bus.ARREADY_S = 1; tick(); bus.ARREADY_S = 0;
    bus.RVALID_S = 1; bus.RREADY_S = 1; bus.RLAST_S = 1; tick(); idle_inputs();
  endtask

  task automatic test_addr_stall();
    logic [3:0] last_pat [5];
    logic [3:0] rdy_pat [5];
    last_pat = '{4'd0, 4'd0, 4'd1, 4'd0, 4'd1};
    rdy_pat  = '{4'd1, 4'd1, 4'd0, 4'd1, 4'd1};
    bus.ARID_M0 = 4'h2; bus.ARADDR_M0 = 32'h0000_FFFF; bus.ARLEN_M0 = 4'd3; bus.ARVALID_M0 = 1;
    tick();
    bus.ARVALID_M0 = 0;
    for (int i = 0; i < 3; i++) begin
      n_vec++; if (bus.ARVALID_S !== 1'b1) begin n_err++; $display("FAIL stall_arvalid[%0d]: got %b want 1", i, bus.ARVALID_S); end
      n_vec++; if (bus.ARADDR_S !== 32'hFFFF || bus.ARLEN_S !== 4'd3) begin n_err++; $display("FAIL stall_payload[%0d]: got %h/%h want ffff/3", i, bus.ARADDR_S, bus.ARLEN_S); end
      tick();
    end
    bus.ARREADY_S = 1;
    tick();
    bus.ARREADY_S = 0;
    // beats: three non-last, one last without RREADY_S, then the real last beat
    for (int i = 0; i < 5; i++) begin
      n_vec++; if (bus.GRANT !== 2'b01) begin n_err++; $display("FAIL stall_grant[%0d]: got %b want 01", i, bus.GRANT); end
      n_vec++; if (bus.ARVALID_S !== 1'b0) begin n_err++; $display("FAIL stall_data_arvalid[%0d]: got %b want 0", i, bus.ARVALID_S); end
      bus.RVALID_S = 1; bus.RREADY_S = rdy_pat[i][0]; bus.RLAST_S = last_pat[i][0];
      tick();
    end
    idle_inputs();
    n_vec++; if (bus.GRANT !== 2'b00) begin n_err++; $display("FAIL stall_grant_end: got %b want 00", bus.GRANT); end
  endtask

  task automatic test_decerr();
    logic [3:0] pat [5];
    int cnt = 0;
    bit done = 0;
    pat = '{4'd1, 4'd0, 4'd1, 4'd0, 4'd1};
    bus.ARID_M1 = 4'h5; bus.ARADDR_M1 = 32'h0002_0000; bus.ARLEN_M1 = 4'd2; bus.ARVALID_M1 = 1;
    tick();
    bus.ARVALID_M1 = 0;
    n_vec++; if (bus.GRANT !== 2'b10) begin n_err++; $display("FAIL derr_grant: got %b want 10", bus.GRANT); end
    for (int i = 0; i < 5; i++) begin
      bus.RREADY_D = pat[i][0];
      #1;
      n_vec++; if (bus.RVALID_D !== 1'b1) begin n_err++; $display("FAIL derr_rvalid[%0d]: got %b want 1", i, bus.RVALID_D); end
      n_vec++; if (bus.ARVALID_S !== 1'b0) begin n_err++; $display("FAIL derr_arvalid[%0d]: got %b want 0", i, bus.ARVALID_S); end
      n_vec++; if (bus.RID_D !== 8'h15 || bus.RRESP_D !== 2'b11 || bus.RDATA_D !== 32'h0) begin n_err++; $display("FAIL derr_beat[%0d]: got %h/%b/%h want 15/11/0", i, bus.RID_D, bus.RRESP_D, bus.RDATA_D); end
      n_vec++; if (bus.RLAST_D !== (cnt == 2)) begin n_err++; $display("FAIL derr_rlast[%0d]: got %b want %b", i, bus.RLAST_D, cnt == 2); end
      tick();
      if (pat[i][0]) begin
        if (cnt == 2) done = 1;
        else cnt++;
      end
    end
    bus.RREADY_D = 0;
    n_vec++; if (bus.RVALID_D !== !done) begin n_err++; $display("FAIL derr_end_rvalid: got %b want %b", bus.RVALID_D, !done); end
    n_vec++; if (bus.GRANT !== 2'b00) begin n_err++; $display("FAIL derr_end_grant: got %b want 00", bus.GRANT); end
  endtask

  task automatic test_alternate();
    logic [1:0] exp_g;
    bus.ARID_M0 = 4'hA; bus.ARADDR_M0 = 32'h0001_FFFF; bus.ARLEN_M0 = 0;
    bus.ARID_M1 = 4'hB; bus.ARADDR_M1 = 32'h0000_0008; bus.ARLEN_M1 = 0;
    bus.ARVALID_M0 = 1; bus.ARVALID_M1 = 1;
    exp_g = 2'b01;
    for (int t = 0; t < 4; t++) begin
      #1;
      n_vec++; if ({bus.ARREADY_M1, bus.ARREADY_M0} !== exp_g) begin n_err++; $display("FAIL alt_rdy[%0d]: got %b want %b", t, {bus.ARREADY_M1, bus.ARREADY_M0}, exp_g); end
      tick();
      n_vec++; if (bus.GRANT !== exp_g) begin n_err++; $display("FAIL alt_grant[%0d]: got %b want %b", t, bus.GRANT, exp_g); end
      n_vec++; if (bus.ARVALID_S !== 1'b1) begin n_err++; $display("FAIL alt_arvalid[%0d]: got %b want 1", t, bus.ARVALID_S); end
      n_vec++; if (bus.ARID_S !== (exp_g[0] ? 8'h0A : 8'h1B)) begin n_err++; $display("FAIL alt_arid[%0d]: got %h want %h", t, bus.ARID_S, exp_g[0] ? 8'h0A : 8'h1B); end
      n_vec++; if ({bus.ARREADY_M1, bus.ARREADY_M0} !== 2'b00) begin n_err++; $display("FAIL alt_busy_rdy[%0d]: got %b want 00", t, {bus.ARREADY_M1, bus.ARREADY_M0}); end
      bus.ARREADY_S = 1; tick(); bus.ARREADY_S = 0;
      bus.RVALID_S = 1; bus.RREADY_S = 1; bus.RLAST_S = 1; tick();
      bus.RVALID_S = 0; bus.RREADY_S = 0; bus.RLAST_S = 0;
      exp_g = {exp_g[0], exp_g[1]};
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid();
    bus.ARID_M1 = 4'h1; bus.ARADDR_M1 = 32'h0003_0000; bus.ARLEN_M1 = 4'd3; bus.ARVALID_M1 = 1;
    tick();
    bus.ARVALID_M1 = 0;
    bus.RREADY_D = 1; tick(); bus.RREADY_D = 0;
    n_vec++; if (bus.RVALID_D !== 1'b1 || bus.RLAST_D !== 1'b0) begin n_err++; $display("FAIL rm_derr_beat2: got %b/%b want 1/0", bus.RVALID_D, bus.RLAST_D); end
    ARESETn = 0; tick(); ARESETn = 1;
    n_vec++; if (bus.RVALID_D !== 1'b0 || bus.GRANT !== 2'b00) begin n_err++; $display("FAIL rm_derr_rst: got %b/%b want 0/00", bus.RVALID_D, bus.GRANT); end
    bus.ARID_M0 = 4'h4; bus.ARADDR_M0 = 32'h40; bus.ARLEN_M0 = 4'd1; bus.ARVALID_M0 = 1;
    tick();
    bus.ARVALID_M0 = 0;
    bus.ARREADY_S = 1; tick(); bus.ARREADY_S = 0;
    n_vec++; if (bus.GRANT !== 2'b01) begin n_err++; $display("FAIL rm_data_grant: got %b want 01", bus.GRANT); end
    ARESETn = 0; tick(); ARESETn = 1;
    n_vec++; if (bus.GRANT !== 2'b00 || bus.ARVALID_S !== 1'b0 || bus.RVALID_D !== 1'b0) begin n_err++; $display("FAIL rm_data_rst: got %b/%b/%b want 00/0/0", bus.GRANT, bus.ARVALID_S, bus.RVALID_D); end
    n_vec++; if (bus.ARID_S !== 8'h00) begin n_err++; $display("FAIL rm_arid_clr: got %h want 00", bus.ARID_S); end
    // last owner before reset was M0; reset must restore M0 priority on a tie
    bus.ARADDR_M0 = 32'h200; bus.ARADDR_M1 = 32'h300;
    bus.ARVALID_M0 = 1; bus.ARVALID_M1 = 1;
    #1;
    n_vec++; if ({bus.ARREADY_M1, bus.ARREADY_M0} !== 2'b01) begin n_err++; $display("FAIL rm_tie_rdy: got %b want 01", {bus.ARREADY_M1, bus.ARREADY_M0}); end
    tick();
    n_vec++; if (bus.GRANT !== 2'b01) begin n_err++; $display("FAIL rm_tie_grant: got %b want 01", bus.GRANT); end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_tie();
    test_addr_stall();
    test_decerr();
    test_alternate();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/axi_ar_arbiter.md
Name: axi_ar_arbiter

Overview:
- Two-master read-address arbiter and sequencer placed in front of the AR address decoder in the AXI interconnect.
- Arbitrates round-robin between master M0 and M1 AR channels and drives the shared slave-side AR bus, which feeds the decoder.
- Holds the grant until the read burst's final beat completes, so the read path routes R data using GRANT.
- Handles addresses outside the slave map by acting as the default slave: accepts the request locally and returns DECERR beats.

Parameters:
- ID_W, 4, master-side ID width
- IDS_W, 8, slave-side ID width: {4-bit master tag, ID}
- ADDR_W, 32, address width
- LEN_W, 4, burst length width
- SIZE_W, 3, burst size width
- DATA_W, 32, read data width for the DECERR responder
- MAP_TOP, 32'h0001_FFFF, highest mapped address (S0 = 0x0–0xFFFF, S1 = 0x10000–0x1FFFF)

Ports:
- ACLK  in  1  clock
- ARESETn  in  1  synchronous active-low reset
- ARID_M0/ARADDR_M0/ARLEN_M0/ARSIZE_M0/ARBURST_M0  in  ID_W/ADDR_W/LEN_W/SIZE_W/2  M0 AR payload
- ARVALID_M0  in  1  M0 request
- ARREADY_M0  out  1  M0 accept
- ARID_M1/ARADDR_M1/ARLEN_M1/ARSIZE_M1/ARBURST_M1  in  same widths as M0  M1 AR payload
- ARVALID_M1  in  1  M1 request
- ARREADY_M1  out  1  M1 accept
- ARID_S/ARADDR_S/ARLEN_S/ARSIZE_S/ARBURST_S  out  IDS_W/ADDR_W/LEN_W/SIZE_W/2  registered payload to decoder
- ARVALID_S  out  1  request to decoder
- ARREADY_S  in  1  selected slave accept
- RVALID_S, RREADY_S, RLAST_S  in  1 each  slave-side R handshake, observed only
- GRANT  out  2  one-hot current owner ({M1,M0}); 2'b00 when idle
- RID_D  out  IDS_W  DECERR response ID
- RDATA_D  out  DATA_W  always 0
- RRESP_D  out  2  DECERR response code
- RLAST_D  out  1  DECERR last beat
- RVALID_D  out  1  DECERR beat valid
- RREADY_D  in  1  master accept of DECERR beat

Behaviour:
- Reset: synchronous; ARESETn=0 at a rising ACLK edge forces state IDLE from any state, including mid-burst.
  - All outputs 0, payload registers 0, beat counter 0, last_grant=M1 (so M0 wins the first tie).
  - No pending transaction survives reset.
- States: IDLE, ADDR, DATA, DERR.
- IDLE:
  - ARREADY_Mx is combinational: ARREADY_M0 = ARVALID_M0 & (~ARVALID_M1 | last_grant==M1); ARREADY_M1 = ARVALID_M1 & (~ARVALID_M0 | last_grant==M0).
  - At most one ARREADY_Mx is high; both are 0 outside IDLE.
- Accept (ARVALID_Mx & ARREADY_Mx):
  - Latch payload; ARID_S = {4'd0, ARID_M0} or {4'd1, ARID_M1}.
  - Set last_grant=x and GRANT = one-hot x.
  - Next state ADDR if ARADDR <= MAP_TOP, else DERR.
- ADDR:
  - ARVALID_S=1 with stable payload, starting the cycle after accept (1-cycle latency).
  - ARREADY_S=1 moves to DATA; ARVALID_S drops the next cycle.
- DATA:
  - ARVALID_S=0.
  - RVALID_S & RREADY_S & RLAST_S moves to IDLE; GRANT clears the same edge.
  - Non-last beats are ignored.
- DERR:
  - ARVALID_S is never asserted; the decoder never sees the request.
  - RVALID_D=1, RID_D=ARID_S, RRESP_D=2'b11, RDATA_D=0, RLAST_D = (cnt==ARLEN latched).
  - On RREADY_D: if cnt==ARLEN, go to IDLE and clear cnt; else cnt+1.
  - Exactly ARLEN+1 beats (ARLEN=15 gives 16 beats; cnt is LEN_W bits, no wrap).
- GRANT is held constant from accept until return to IDLE.
  - Payload registers keep their last value in IDLE; only ARVALID_S qualifies them.
- Single outstanding transaction: a new request can be accepted no earlier than the cycle after return to IDLE.
  - Back-to-back throughput is 1 request per (2 + slave latency) cycles minimum.
- Simultaneous: a master holding ARVALID across a lost arbitration keeps its request; it wins the next IDLE cycle if the other master was just granted.
- Address 0x1FFFF routes to ADDR; 0x20000 routes to DERR.

Test Plan:
- Reset then ARVALID_M0=ARVALID_M1=1, ARADDR=0x100 / 0x10004 -> M0 accepted first (ARREADY_M0=1, GRANT=01, ARID_S={4'd0,ID}); after RLAST handshake, M1 accepted next with GRANT=10.
- M0 ARADDR=0x0000_FFFF, ARLEN=3; ARREADY_S delayed 3 cycles -> ARVALID_S held 3 cycles with stable payload; GRANT=01 until the 4th R beat with RLAST_S.
- M1 ARADDR=0x0002_0000, ARLEN=2, ARID=4'h5 -> ARVALID_S never rises; 3 DECERR beats with RID_D=8'h15, RRESP_D=2'b11, RLAST_D only on beat 3; RREADY_D toggling stalls the count.
- Both masters requesting continuously for 4 transactions -> grants alternate M0, M1, M0, M1.
- ARESETn=0 during DATA and again during DERR beat 2 -> next cycle IDLE, GRANT=0, RVALID_D=0, ARVALID_S=0; first request afterward grants M0 on a tie.
